flexbex_ibex_rf_wr_arbiter: RTL
===============================

# flexbex_ibex_rf_wr_arbiter

Shares the register file's single write port among NUM_REQ writeback requesters (ALU, LSU, multiplier/divider) using valid/ready handshakes and round-robin arbitration. The winning request is registered into a one-entry write stage that drives the register file write port on the following cycle. The same registered stage is exported as a forwarding source, so the ID stage can bypass a write that has not yet landed in the array. It sits between the writeback sources and the register file.

## Interface

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8)
- DATA_WIDTH, 32, write data width
- ADDR_WIDTH, 5, register address width (4 for RV32E)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- stall_i  in  1  when 1, no grant this cycle
- req_valid_i  in  NUM_REQ  per-requester write request
- req_ready_o  out  NUM_REQ  one-hot grant; the handshake completes on valid&ready
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- req_data_i  in  NUM_REQ*DATA_WIDTH  packed data, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
- waddr_a_o  out  ADDR_WIDTH  register file write address
- wdata_a_o  out  DATA_WIDTH  register file write data
- we_a_o  out  1  register file write enable
- fwd_valid_o  out  1  equals we_a_o; registered stage holds a pending write
- fwd_addr_o  out  ADDR_WIDTH  equals waddr_a_o
- fwd_data_o  out  DATA_WIDTH  equals wdata_a_o

## Operation

- **Priority pointer.** rr_ptr, range 0..NUM_REQ-1, marks the highest-priority requester.
- **Search order.** rr_ptr, rr_ptr+1, … mod NUM_REQ.
- **Grant.** g is the first requester in search order with req_valid_i set. req_ready_o is one-hot at bit g.
- **Grant conditions.** req_ready_o = 0 when any of these hold:
  - stall_i = 1
  - rst = 1
  - no requester is valid
- **Readiness.** req_ready_o depends combinationally on req_valid_i, stall_i and rr_ptr. It does not depend on stage occupancy, because the stage drains every cycle.
- **On a grant at edge t:**
  - the stage loads waddr_a_o ← req_addr(g) and wdata_a_o ← req_data(g)
  - we_a_o ← (req_addr(g) ≠ 0)
  - rr_ptr ← (g+1) mod NUM_REQ
- **No grant.** we_a_o ← 0. waddr_a_o, wdata_a_o and rr_ptr hold their values.
- **x0 writes.** The request is accepted (ready asserted) and the pointer advances, but we_a_o stays 0.
- **Fairness.** With stall_i = 0, a continuously valid requester is granted within NUM_REQ cycles.
- **Data ordering.** Nothing is dropped or reordered per requester. Accepted data appears on the port exactly once.
- **Reset values** (asynchronous, immediate on rst rising):
  - we_a_o = 0
  - waddr_a_o = 0
  - wdata_a_o = 0
  - rr_ptr = 0
  - req_ready_o = 0
  - fwd_* follow the stage (0)
- **Reset mid-operation.** A pending write in the stage is discarded and not written. Requesters re-present after reset.

## Timing

- **Acceptance to write.** Request accepted at edge t gives we_a_o = 1 during cycle t..t+1, and the register file captures it at edge t+1. Latency is 1 cycle.
- **Throughput.** One write per cycle sustained. Back-to-back grants produce back-to-back we_a_o.
- **Stall.** stall_i takes effect the same cycle (combinational ready gating). The write already in the stage still completes the next cycle.
- **Simultaneous requests.** Exactly one is granted. The others see ready = 0 and must hold valid, address and data stable until granted.
- **Forwarding.** fwd_* are registered outputs with no combinational path from req_*.
- **Same-cycle read.** A read of fwd_addr_o in the same cycle returns stale register file data, so the consumer must select fwd_data_o when fwd_valid_o is set and the addresses match.

## Test plan

- **Reset.** Hold rst for 3 cycles with all requesters valid → req_ready_o = 000, we_a_o = 0, waddr_a_o = 0, wdata_a_o = 0. After deassert, first grant goes to requester 0.
- **Single requester.** Requester 1 only, addr = 5, data = 0xDEADBEEF → ready[1] = 1 that cycle. Next cycle we_a_o = 1, waddr_a_o = 5, wdata_a_o = 0xDEADBEEF, fwd_valid_o = 1.
- **Round-robin.** All 3 valid continuously for 6 cycles, addr = k+1 → grant order 0,1,2,0,1,2. we_a_o high for 6 consecutive cycles with waddr 1,2,3,1,2,3.
- **x0 write.** Requester 2 writes addr = 0, data = 0x1234 → ready[2] = 1, next cycle we_a_o = 0, rr_ptr advances to 0.
- **Stall.** Requesters 0 and 1 valid, stall_i = 1 for 4 cycles → ready = 00, we_a_o = 0 after the first cycle. Release → grants 0 then 1 on consecutive cycles.
- **Reset mid-write.** Grant at edge t, assert rst before edge t+1 → we_a_o drops to 0 immediately and no write is issued.

Source files
------------

// File: rtl/flexbex_ibex_rf_wr_arbiter.sv
// Round-robin arbiter that funnels writeback requests into the register file
// write port through a one-entry registered stage, also used as a bypass source.
module flexbex_ibex_rf_wr_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [ADDR_WIDTH-1:0]         waddr_a_o,
  output logic [DATA_WIDTH-1:0]         wdata_a_o,
  output logic                          we_a_o,
  output logic                          fwd_valid_o,
  output logic [ADDR_WIDTH-1:0]         fwd_addr_o,
  output logic [DATA_WIDTH-1:0]         fwd_data_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      gidx;
  logic [PTR_W-1:0]      next_ptr;
  logic                  found;
  logic                  fire;
  logic [NUM_REQ-1:0]    grant;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  we_q;

  // Scan from rr_ptr upward (wrapping) and take the first valid requester.
  always_comb begin
    int idx;
    int g;
    found = 1'b0;
    g     = 0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
    gidx     = PTR_W'(g);
    next_ptr = PTR_W'((g + 1) % NUM_REQ);
  end

  always_comb begin
    grant = '0;
    grant[gidx] = 1'b1;
  end

  assign fire        = found && !stall_i && !rst;
  assign req_ready_o = fire ? grant : '0;
  assign sel_addr    = req_addr_i[gidx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_data    = req_data_i[gidx*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (fire) begin
      rr_ptr  <= next_ptr;
      waddr_q <= sel_addr;
      wdata_q <= sel_data;
      we_q    <= (sel_addr != '0);
    end else begin
      we_q    <= 1'b0;
    end
  end

  assign waddr_a_o   = waddr_q;
  assign wdata_a_o   = wdata_q;
  assign we_a_o      = we_q;
  assign fwd_valid_o = we_q;
  assign fwd_addr_o  = waddr_q;
  assign fwd_data_o  = wdata_q;

endmodule
